// File: rtl/matmul_feeder.sv
// Host-loaded weight/input buffers streamed to the matmul core as start -> N weights -> T inputs,
// then one result beat is captured. Optional WAIT_RES timeout when MMF_TIMEOUT_EN is defined.
module matmul_feeder #(
  parameter int N       = 5,
  parameter int T       = 10,
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        wr_en_i,
  input  logic        wr_sel_i,
  input  logic [3:0]  wr_addr_i,
  input  logic [39:0] wr_data_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        mm_start_o,
  output logic [39:0] weight_o,
  output logic        enw_o,
  output logic [39:0] in_o,
  output logic        eni_o,
  input  logic [39:0] mm_out_i,
  input  logic        mm_val_i,
  input  logic        mm_ov_i,
  output logic [39:0] res_o,
  output logic        ov_o,
  output logic        err_o
);

  localparam int NUM_LANES = 5;
  localparam int VEC_W     = 8;
  localparam logic [4:0] N_LIM  = 5'(N);
  localparam logic [4:0] T_LIM  = 5'(T);
  localparam logic [3:0] N_LAST = 4'(N - 1);
  localparam logic [3:0] T_LAST = 4'(T - 1);

  typedef enum logic [2:0] {IDLE, KICK, SEND_W, SEND_I, WAIT_RES, FIN} state_t;

  state_t state;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       wr_ok;

  // Row storage is a full 16 deep so the 4-bit beat counter indexes it directly.
  logic [NUM_LANES-1:0][VEC_W-1:0] wbuf [16];
  logic [NUM_LANES-1:0][VEC_W-1:0] ibuf [16];

  assign cnt_nx = cnt + 4'd1;
  assign wr_ok  = wr_en_i && !busy_o &&
                  (wr_sel_i ? ({1'b0, wr_addr_i} < T_LIM) : ({1'b0, wr_addr_i} < N_LIM));

  always_ff @(posedge CLK) begin
    if (wr_ok) begin
      if (wr_sel_i) ibuf[wr_addr_i] <= wr_data_i;
      else          wbuf[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef MMF_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
`else
  localparam bit TIMEOUT_IGNORED = (TIMEOUT > 0);
  assign err_o = 1'b0 & TIMEOUT_IGNORED;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      mm_start_o <= 1'b0;
      weight_o   <= '0;
      enw_o      <= 1'b0;
      in_o       <= '0;
      eni_o      <= 1'b0;
      res_o      <= '0;
      ov_o       <= 1'b0;
`ifdef MMF_TIMEOUT_EN
      tcnt       <= '0;
      err_o      <= 1'b0;
`endif
    end else begin
      mm_start_o <= 1'b0;
      done_o     <= 1'b0;
      case (state)
        IDLE: if (start_i) begin
          state      <= KICK;
          busy_o     <= 1'b1;
          mm_start_o <= 1'b1;
`ifdef MMF_TIMEOUT_EN
          err_o      <= 1'b0;
`endif
        end
        KICK: begin
          state    <= SEND_W;
          enw_o    <= 1'b1;
          weight_o <= wbuf[0];
          cnt      <= '0;
        end
        // cnt holds the row currently on the bus, so the last beat is row N-1 / T-1.
        SEND_W: if (cnt == N_LAST) begin
          state    <= SEND_I;
          enw_o    <= 1'b0;
          weight_o <= '0;
          eni_o    <= 1'b1;
          in_o     <= ibuf[0];
          cnt      <= '0;
        end else begin
          cnt      <= cnt_nx;
          weight_o <= wbuf[cnt_nx];
        end
        SEND_I: if (cnt == T_LAST) begin
          state <= WAIT_RES;
          eni_o <= 1'b0;
          in_o  <= '0;
          cnt   <= '0;
`ifdef MMF_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end else begin
          cnt  <= cnt_nx;
          in_o <= ibuf[cnt_nx];
        end
        WAIT_RES: if (mm_val_i) begin
          res_o  <= mm_out_i;
          ov_o   <= mm_ov_i;
          state  <= FIN;
          done_o <= 1'b1;
          busy_o <= 1'b0;
        end
`ifdef MMF_TIMEOUT_EN
        else if (tcnt == TO_LAST) begin
          err_o  <= 1'b1;
          ov_o   <= 1'b0;
          state  <= FIN;
          done_o <= 1'b1;
          busy_o <= 1'b0;
          tcnt   <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
`endif
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_feeder.sv
// Directed/randomized bench for matmul_feeder: a queue-free array model of the buffers and the
// expected result registers predicts every beat of each job.
module tb_matmul_feeder;
  localparam int N = 5;
  localparam int T = 10;
`ifdef MMF_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic        CLK = 1'b0, RSTN = 1'b0;
  logic        wr_en_i = 1'b0, wr_sel_i = 1'b0;
  logic [3:0]  wr_addr_i = '0;
  logic [39:0] wr_data_i = '0;
  logic        start_i = 1'b0;
  logic        busy_o, done_o, mm_start_o, enw_o, eni_o, ov_o, err_o;
  logic [39:0] weight_o, in_o, res_o;
  logic [39:0] mm_out_i = '0;
  logic        mm_val_i = 1'b0, mm_ov_i = 1'b0;

  matmul_feeder #(.N(N), .T(T), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .wr_en_i(wr_en_i), .wr_sel_i(wr_sel_i), .wr_addr_i(wr_addr_i),
    .wr_data_i(wr_data_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .mm_start_o(mm_start_o), .weight_o(weight_o), .enw_o(enw_o), .in_o(in_o), .eni_o(eni_o),
    .mm_out_i(mm_out_i), .mm_val_i(mm_val_i), .mm_ov_i(mm_ov_i), .res_o(res_o), .ov_o(ov_o),
    .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int fails = 0;
  logic [39:0] mw [0:15];
  logic [39:0] mi [0:15];
  logic [39:0] m_res = '0;
  logic        m_ov  = 1'b0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [39:0] rnd40();
    return {8'($urandom()), 32'($urandom())};
  endfunction

  task automatic chk_zero(input string tag);
    chk1({tag, "_busy"}, busy_o, 1'b0);
    chk1({tag, "_done"}, done_o, 1'b0);
    chk1({tag, "_start"}, mm_start_o, 1'b0);
    chk1({tag, "_enw"}, enw_o, 1'b0);
    chk1({tag, "_eni"}, eni_o, 1'b0);
    chk({tag, "_w"}, weight_o, 40'h0);
    chk({tag, "_in"}, in_o, 40'h0);
    chk({tag, "_res"}, res_o, 40'h0);
    chk1({tag, "_ov"}, ov_o, 1'b0);
    chk1({tag, "_err"}, err_o, 1'b0);
  endtask

  // Host write issued in IDLE: lands only for rows inside the configured depth.
  task automatic wr(input logic sel, input logic [3:0] a, input logic [39:0] d);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = a; wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
    if (!sel && int'(a) < N) mw[a] = d;
    if (sel && int'(a) < T) mi[a] = d;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) wr(1'b0, 4'(i), rnd40());
    for (int j = 0; j < T; j++) wr(1'b1, 4'(j), rnd40());
  endtask

  // One job: optional busy-time disturbance, same-cycle write with start, reset on the 3rd
  // input beat, result after lat idle WAIT_RES cycles or (give_val=0) a timeout.
  task automatic job(input bit disturb, input bit same_wr, input bit rst_mid, input bit give_val,
                     input int lat, input logic [39:0] rval, input logic rov);
    logic [39:0] sw;
    sw = rnd40();
    start_i = 1'b1;
    if (same_wr) begin
      wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_addr_i = 4'd2; wr_data_i = sw;
      mw[2] = sw;
    end
    tick();
    start_i = 1'b0; wr_en_i = 1'b0;
    m_err = 1'b0;
    chk1("kick_start", mm_start_o, 1'b1);
    chk1("kick_busy", busy_o, 1'b1);
    chk1("kick_enw", enw_o, 1'b0);
    chk1("kick_err", err_o, m_err);
    for (int i = 0; i < N; i++) begin
      if (disturb) begin
        wr_en_i = 1'b1; wr_sel_i = 1'b0; wr_addr_i = 4'd0; wr_data_i = '1;
        start_i = 1'b1; mm_val_i = 1'b1; mm_out_i = rnd40(); mm_ov_i = ~m_ov;
      end
      tick();
      chk1("w_en", enw_o, 1'b1);
      chk($sformatf("w_row%0d", i), weight_o, mw[i]);
      chk1("w_start", mm_start_o, 1'b0);
      chk("w_res_hold", res_o, m_res);
    end
    wr_en_i = 1'b0; start_i = 1'b0; mm_val_i = 1'b0;
    for (int j = 0; j < T; j++) begin
      tick();
      chk1("i_en", eni_o, 1'b1);
      chk($sformatf("i_row%0d", j), in_o, mi[j]);
      chk1("i_enw", enw_o, 1'b0);
      chk("i_w0", weight_o, 40'h0);
      if (rst_mid && j == 2) begin
        RSTN = 1'b0;
        #1;
        chk_zero("rst_mid");
        m_res = '0; m_ov = 1'b0; m_err = 1'b0;
        tick();
        RSTN = 1'b1;
        tick();
        chk_zero("rst_after");
        return;
      end
    end
    if (disturb) begin
      mm_val_i = 1'b1; mm_out_i = rnd40(); mm_ov_i = ~m_ov;
    end
    tick();
    mm_val_i = 1'b0;
    chk1("wait_busy", busy_o, 1'b1);
    chk1("wait_done", done_o, 1'b0);
    chk1("wait_eni", eni_o, 1'b0);
    chk("wait_in0", in_o, 40'h0);
    chk("wait_res_hold", res_o, m_res);
    if (give_val) begin
      for (int k = 0; k < lat; k++) begin
        tick();
        chk1("lat_done", done_o, 1'b0);
        chk1("lat_busy", busy_o, 1'b1);
      end
      mm_val_i = 1'b1; mm_out_i = rval; mm_ov_i = rov;
      m_res = rval; m_ov = rov;
      tick();
      mm_val_i = 1'b0;
    end else begin
      for (int k = 0; k < TO - 1; k++) begin
        tick();
        chk1("to_done_early", done_o, 1'b0);
      end
      m_ov = 1'b0; m_err = 1'b1;
      tick();
    end
    chk1("fin_done", done_o, 1'b1);
    chk1("fin_busy", busy_o, 1'b0);
    chk("fin_res", res_o, m_res);
    chk1("fin_ov", ov_o, m_ov);
    chk1("fin_err", err_o, m_err);
    tick();
    chk1("post_done", done_o, 1'b0);
    chk1("post_busy", busy_o, 1'b0);
    chk("post_res", res_o, m_res);
  endtask

  initial begin
    repeat (2) tick();
    chk_zero("reset");
    RSTN = 1'b1;
    tick();
    chk_zero("reset_rel");

    for (int i = 0; i < N; i++) wr(1'b0, 4'(i), 40'h0101010101 * 40'(i + 1));
    for (int j = 0; j < T; j++) wr(1'b1, 4'(j), 40'(j));
    job(1'b0, 1'b0, 1'b0, 1'b1, 0, 40'h0A0B0C0D0E, 1'b1);

    // Busy-time writes/starts/results are all ignored; then out-of-range rows are dropped.
    job(1'b1, 1'b0, 1'b0, 1'b1, 2, rnd40(), 1'b0);
    wr(1'b0, 4'd7, 40'hDEADBEEF00);
    wr(1'b1, 4'd12, 40'hDEADBEEF11);
    job(1'b0, 1'b0, 1'b0, 1'b1, 1, rnd40(), 1'b1);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1,
          $urandom_range(0, 4), rnd40(), 1'($urandom_range(0, 1)));
    end

    job(1'b0, 1'b0, 1'b1, 1'b1, 0, rnd40(), 1'b0);
    fill_random();
    job(1'b0, 1'b1, 1'b0, 1'b1, 3, rnd40(), 1'b1);

`ifdef MMF_TIMEOUT_EN
    job(1'b0, 1'b0, 1'b0, 1'b0, 0, 40'h0, 1'b0);
    job(1'b0, 1'b0, 1'b0, 1'b1, 1, rnd40(), 1'b1);
`else
    job(1'b0, 1'b0, 1'b0, 1'b1, 70, rnd40(), 1'b0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
